// File: rtl/store_buffer.sv
// Write-posting store buffer in front of a single-port memory hierarchy.
// Loads take the port first and are forwarded from the youngest matching buffered store.
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  input  logic                    flush,
  output logic                    empty,
  output logic                    mem_write_en,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [15:0]             fwd_count,
  output logic [15:0]             drain_count,
  output logic [15:0]             stall_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [DATA_WIDTH-1:0] data_hold;
  logic                  rsp_pending;
  logic                  rsp_fwd;
  logic [DATA_WIDTH-1:0] rsp_fwd_data;

  logic                  full;
  logic                  accept;
  logic                  load_acc;
  logic                  store_acc;
  logic                  drain;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return (en && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction

  assign full      = (occupancy == OW'(DEPTH));
  assign empty     = (occupancy == '0);
  assign req_ready = !full && !(req_write && flush);
  assign accept    = req_valid && req_ready;
  assign load_acc  = accept && !req_write;
  assign store_acc = accept && req_write;
  assign drain     = full || (!load_acc && !empty);

  // Scan oldest to youngest so the last hit wins, giving the youngest match.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (OW'(k) < occupancy && addr_q[head + PW'(k)] == req_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head + PW'(k)];
      end
    end
  end

  always_comb begin
    mem_write_en   = drain;
    mem_address    = addr_hold;
    mem_write_data = data_hold;
    if (drain) begin
      mem_address    = addr_q[head];
      mem_write_data = data_q[head];
    end else if (load_acc) begin
      mem_address = req_addr;
    end
  end

  assign rsp_valid = rsp_pending;
  assign rsp_data  = !rsp_pending ? '0 : (rsp_fwd ? rsp_fwd_data : mem_read_data);

  always_ff @(posedge clk) begin
    if (store_acc) begin
      addr_q[tail] <= req_addr;
      data_q[tail] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      occupancy    <= '0;
      addr_hold    <= '0;
      data_hold    <= '0;
      rsp_pending  <= 1'b0;
      rsp_fwd      <= 1'b0;
      rsp_fwd_data <= '0;
      fwd_count    <= '0;
      drain_count  <= '0;
      stall_count  <= '0;
    end else begin
      if (drain)     head <= head + PW'(1);
      if (store_acc) tail <= tail + PW'(1);
      if (store_acc && !drain)      occupancy <= occupancy + OW'(1);
      else if (!store_acc && drain) occupancy <= occupancy - OW'(1);
      addr_hold    <= mem_address;
      data_hold    <= mem_write_data;
      rsp_pending  <= load_acc;
      rsp_fwd      <= load_acc && fwd_hit;
      rsp_fwd_data <= fwd_data;
      fwd_count    <= sat_inc(fwd_count, load_acc && fwd_hit);
      drain_count  <= sat_inc(drain_count, drain);
      stall_count  <= sat_inc(stall_count, req_valid && !req_ready);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios then random traffic, checked against a
// queue-based model of buffered stores and port arbitration.
module tb_store_buffer;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic                 clk;
  logic                 rst;
  logic                 req_valid;
  logic                 req_write;
  logic [AW-1:0]        req_addr;
  logic [DW-1:0]        req_wdata;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 flush;
  logic                 empty;
  logic                 mem_write_en;
  logic [AW-1:0]        mem_address;
  logic [DW-1:0]        mem_write_data;
  logic [DW-1:0]        mem_read_data;
  logic [$clog2(DEPTH):0] occupancy;
  logic [15:0]          fwd_count;
  logic [15:0]          drain_count;
  logic [15:0]          stall_count;

  int total = 0;
  int bad   = 0;

  ent_t          q[$];
  logic [AW-1:0] m_last_addr;
  logic          m_pend;
  logic          m_pend_fwd;
  logic [DW-1:0] m_pend_data;
  logic [15:0]   m_fwd;
  logic [15:0]   m_drn;
  logic [15:0]   m_stl;

  store_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .flush(flush), .empty(empty),
    .mem_write_en(mem_write_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .occupancy(occupancy), .fwd_count(fwd_count),
    .drain_count(drain_count), .stall_count(stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] sat(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last_addr = '0;
    m_pend      = 1'b0;
    m_pend_fwd  = 1'b0;
    m_pend_data = '0;
    m_fwd       = '0;
    m_drn       = '0;
    m_stl       = '0;
  endtask

  task automatic check_counters();
    check_output("occupancy", 32'(occupancy), 32'(q.size()));
    check_output("empty", 32'(empty), 32'(q.size() == 0));
    check_output("fwd_count", 32'(fwd_count), 32'(m_fwd));
    check_output("drain_count", 32'(drain_count), 32'(m_drn));
    check_output("stall_count", 32'(stall_count), 32'(m_stl));
  endtask

  // One clock cycle: drive, check the cycle's outputs against the model, advance the model.
  task automatic apply_stimulus(input logic v, input logic w, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic fl, input logic [DW-1:0] rd);
    logic          exp_ready, ld, st, dr, hit;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] hd;
    int            qs;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    flush = fl; mem_read_data = rd;
    #1;
    qs = q.size();
    check_output("rsp_valid", 32'(rsp_valid), 32'(m_pend));
    if (m_pend)
      check_output("rsp_data", rsp_data, m_pend_fwd ? m_pend_data : rd);
    else
      check_output("rsp_data_idle", rsp_data, 32'h0);
    exp_ready = (qs < DEPTH) && !(w && fl);
    check_output("req_ready", 32'(req_ready), 32'(exp_ready));
    ld = v && exp_ready && !w;
    st = v && exp_ready && w;
    dr = (qs == DEPTH) || (!ld && qs > 0);
    check_output("mem_write_en", 32'(mem_write_en), 32'(dr));
    if (dr) begin
      exp_addr = q[0].a;
      check_output("mem_write_data", mem_write_data, q[0].d);
    end else if (ld) begin
      exp_addr = a;
    end else begin
      exp_addr = m_last_addr;
    end
    check_output("mem_address", 32'(mem_address), 32'(exp_addr));
    check_counters();
    hit = 1'b0;
    hd  = '0;
    for (int i = qs - 1; i >= 0; i--) begin
      if (q[i].a == a) begin
        hit = 1'b1;
        hd  = q[i].d;
        break;
      end
    end
    m_last_addr = exp_addr;
    if (dr) begin
      void'(q.pop_front());
      m_drn = sat(m_drn);
    end
    if (st) q.push_back('{a: a, d: d});
    if (ld && hit) m_fwd = sat(m_fwd);
    if (v && !exp_ready) m_stl = sat(m_stl);
    m_pend      = ld;
    m_pend_fwd  = ld && hit;
    m_pend_data = hd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    flush = 1'b0; mem_read_data = '0;
    model_reset();
    #3;
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("reset_rsp_data", rsp_data, 32'h0);
    check_output("reset_mem_write_en", 32'(mem_write_en), 32'h0);
    check_output("reset_mem_address", 32'(mem_address), 32'h0);
    check_output("reset_mem_write_data", mem_write_data, 32'h0);
    check_counters();
    #14 rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] in-order drain of three stores");
    apply_stimulus(1, 1, 8'h10, 32'hA, 0, $urandom);
    apply_stimulus(1, 1, 8'h11, 32'hB, 0, $urandom);
    apply_stimulus(1, 1, 8'h12, 32'hC, 0, $urandom);
    apply_stimulus(0, 0, 8'h00, 32'h0, 0, $urandom);
    apply_stimulus(0, 0, 8'h00, 32'h0, 0, $urandom);
    check_output("drain_count_after_3", 32'(drain_count), 32'd3);

    $display("[TB] forward from youngest store");
    apply_stimulus(1, 1, 8'h20, 32'h1, 0, $urandom);
    apply_stimulus(1, 1, 8'h20, 32'h2, 0, $urandom);
    apply_stimulus(1, 0, 8'h20, 32'h0, 0, $urandom);
    check_output("fwd_rsp_data", rsp_data, 32'h2);
    apply_stimulus(0, 0, 8'h00, 32'h0, 0, $urandom);
    check_output("fwd_count_after", 32'(fwd_count), 32'd1);

    $display("[TB] load miss");
    apply_stimulus(1, 0, 8'h30, 32'h0, 0, $urandom);
    apply_stimulus(0, 0, 8'h00, 32'h0, 0, 32'hDEAD);

    $display("[TB] alternating stores and loads");
    for (int i = 0; i < 8; i++)
      apply_stimulus(1, i[0], (i[0] ? 8'h40 + 8'(i) : 8'h40), 32'h100 + 32'(i), 0, $urandom);

    $display("[TB] flush blocks stores");
    apply_stimulus(1, 1, 8'h60, 32'h66, 0, $urandom);
    apply_stimulus(1, 1, 8'h61, 32'h67, 1, $urandom);
    apply_stimulus(1, 1, 8'h62, 32'h68, 1, $urandom);
    apply_stimulus(1, 0, 8'h60, 32'h0, 1, $urandom);
    apply_stimulus(0, 0, 8'h00, 32'h0, 0, $urandom);

    $display("[TB] asynchronous reset mid-drain");
    apply_stimulus(1, 1, 8'h50, 32'h55, 0, $urandom);
    apply_stimulus(1, 0, 8'h51, 32'h0, 0, $urandom);
    req_valid = 1'b0; req_write = 1'b0; flush = 1'b0;
    #1;
    check_output("pre_reset_mem_write_en", 32'(mem_write_en), 32'h1);
    check_output("pre_reset_rsp_valid", 32'(rsp_valid), 32'h1);
    rst = 1'b0;
    #1;
    check_output("async_mem_write_en", 32'(mem_write_en), 32'h0);
    check_output("async_occupancy", 32'(occupancy), 32'h0);
    check_output("async_empty", 32'(empty), 32'h1);
    check_output("async_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    apply_stimulus(0, 0, 8'h00, 32'h0, 0, $urandom);
    apply_stimulus(0, 0, 8'h00, 32'h0, 0, $urandom);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic          v, w, fl;
      logic [AW-1:0] a;
      v  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1) == 1;
      fl = ($urandom_range(0, 7) == 0);
      a  = 8'h70 + 8'($urandom_range(0, 3));
      apply_stimulus(v, w, a, $urandom, fl, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
